fp16_divider: RTL
=================

# fp16_divider

Iterative IEEE-754 binary16 divider computing `a / b`. It is the inverse companion to the pipelined FP16 multiplier, using the same special-value encodings and round-to-nearest-even. It sits behind a valid/ready handshake on both sides and holds one operation at a time. A restoring mantissa divider retires one quotient bit per cycle.

## Interface
- No parameters. All widths are fixed by the binary16 format.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — the operand pair is valid.
- `in_ready`  out  1  — the block can accept operands. Equals `(state == IDLE)`.
- `a`  in  16  — dividend, binary16.
- `b`  in  16  — divisor, binary16.
- `out_valid`  out  1  — `out` is valid.
- `out_ready`  in  1  — the consumer accepts `out`.
- `out`  out  16  — quotient, binary16. Registered.
- `out_dbz`  out  1  — divide-by-zero: finite nonzero `a` with zero `b`. Registered, qualified by `out_valid`.

## Operation
- **FSM states:** IDLE, DIVIDE, ROUND, DONE.
  - IDLE → DIVIDE or DONE on `in_valid & in_ready`.
  - DIVIDE → ROUND after 12 iterations.
  - ROUND → DONE.
  - DONE → IDLE on `out_ready`.
- **Operand capture:** operands are captured on acceptance. Later changes on `a`/`b` are ignored.
- **Input decode:** sign = bit 15, exp = [14:10], frac = [9:0]. Any input with exp == 0 is treated as zero (DAZ).
- **Special cases** are resolved at acceptance and go directly to DONE, in this priority order:
  - NaN operand, 0/0, or inf/inf → `16'h7e00`.
  - inf/x, or x/0 with x nonzero → `{s, 15'h7c00}`. `out_dbz` = 1 only for finite x / 0.
  - 0/x or x/inf → `{s, 15'h0000}`.
  - Here `s = sign_a ^ sign_b`.
- **Normal path, setup:**
  - `ma = {1, frac_a}`, `mb = {1, frac_b}` (11 bits each).
  - If `ma < mb`, the partial remainder is preset to `ma << 1`; otherwise it is `ma`.
  - Exponent, signed 7-bit: `e = exp_a - exp_b + 15 - (ma < mb)`.
- **Normal path, DIVIDE:** 12 restoring steps produce q[11:0] (1 integer bit, 10 fraction bits, 1 guard bit). Each step:
  - if `rem >= mb`: set the quotient bit to 1 and subtract `mb`.
  - then `rem <<= 1`.
  - The partial remainder is 12 bits.
- **Normal path, ROUND:**
  - sticky = `(rem != 0)`.
  - RNE: increment when `guard & (sticky | lsb)`.
  - A mantissa carry to 2.0 sets `e += 1` and the fraction to 0.
  - If `e >= 31` after rounding → `{s, 7c00}`.
  - If `e >= 1` → `{s, e[4:0], frac}`.
  - If `e <= 0`, see Configuration.
- **Reset:** `state` = IDLE, `out_valid` = 0, `out` = 16'h0000, `out_dbz` = 0, `in_ready` = 1.
- **Reset mid-operation** aborts the operation. No result is produced.

## Timing
- `in_ready` is combinational from state. No operand is accepted while in DONE, including in the same cycle as the DONE → IDLE handshake.
- **Normal latency:** `out_valid` rises 14 cycles after the accepting edge (12 DIVIDE + 1 ROUND + 1 registering into DONE).
- **Special-case latency:** `out_valid` rises on the cycle after the accepting edge.
- `out` and `out_dbz` are stable while `out_valid & ~out_ready`.
- `out_valid` falls on the edge where `out_valid & out_ready`.
- Maximum throughput: one normal operation per 15 cycles.

## Configuration
- **`FP16_DIV_SUBNORMAL_EN` defined:** when `e <= 0`, {q, sticky} is right-shifted by `1 - e` before RNE rounding. Shifted-out bits OR into sticky. A shift of 12 or more yields only sticky. Output is `{s, 5'h00, frac}`. A round-up into `16'h0400` is a valid normal result.
- **Undefined:** when `e <= 0`, output is `{s, 15'h0000}` (flush-to-zero).

## Structure
- **Shared package `fp16_pkg`:**
  - `FP16_QNAN = 16'h7e00`
  - `FP16_INF = 15'h7c00`
  - `FP16_BIAS = 15`
  - field widths (EXP_W = 5, FRAC_W = 10)
  - the divider state enum.
- **Sub-module `fp16_mant_divider`:** the 12-iteration restoring core. Inputs are start, ma, mb, and the preset flag. Outputs are done, q[11:0], and sticky. The top-level FSM handles special cases, the exponent, rounding, and the handshake.

## Test plan
- **1.0 / 2.0:** `3C00 / 4000` → `out` = `3800`, `out_dbz` = 0, `out_valid` 14 cycles after acceptance.
- **RNE on a repeating quotient:** `3C00 / 4200` (1/3) → `3555`. Also `C000 / 3C00` → `C000`.
- **Overflow:** `7BFF / 3800` → `7C00`.
- **Special cases, 1-cycle latency each:**
  - `3C00 / 0000` → `7C00`, `out_dbz` = 1.
  - `0000 / 0000` → `7E00`, `out_dbz` = 0.
  - `8000 / 3C00` → `8000`.
  - `7C00 / 7C00` → `7E00`.
  - `7E01 / 3C00` → `7E00`.
- **Underflow:** `0400 / 4000` → `0200` with `FP16_DIV_SUBNORMAL_EN`; `0000` without it.
- **Backpressure and reset:**
  - Hold `out_ready` = 0 for 5 cycles → `out` is held, `in_ready` = 0; `out_valid` drops the cycle after `out_ready` = 1.
  - Assert `rst_n` = 0 mid-DIVIDE → `out_valid` = 0 and `in_ready` = 1 immediately, with no stale result after release.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared binary16 definitions: special encodings, field widths and the
// divider control state enum.
package fp16_pkg;

    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int FP16_BIAS = 15;

    localparam logic [15:0] FP16_QNAN = 16'h7e00;
    localparam logic [14:0] FP16_INF  = 15'h7c00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } div_state_e;

endpackage

// File: rtl/fp16_mant_divider.sv
// Restoring mantissa divider: one quotient bit per cycle, 12 bits total
// (integer bit, 10 fraction bits, guard). The first step is taken on the
// same edge that loads the operands, so done rises 12 edges after start.
module fp16_mant_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] ma,
    input  logic [10:0] mb,
    input  logic        preset,
    output logic        done,
    output logic [11:0] q,
    output logic        sticky
);

    localparam logic [3:0] N_STEPS = 4'd12;

    logic [3:0]  count_q, count_d;
    logic [11:0] rem_q, rem_d;
    logic [11:0] q_q, q_d;
    logic [10:0] mb_q, mb_d;

    logic [11:0] rem_in;
    logic [11:0] q_in;
    logic [10:0] divisor;
    logic [11:0] diff;
    logic        ge;
    logic        step;

    // One restoring step, fed either from fresh operands or the held remainder
    always_comb begin
        step    = start | (count_q != N_STEPS);
        rem_in  = start ? (preset ? {ma, 1'b0} : {1'b0, ma}) : rem_q;
        divisor = start ? mb : mb_q;
        q_in    = start ? 12'd0 : q_q;
        ge      = rem_in >= {1'b0, divisor};
        diff    = ge ? (rem_in - {1'b0, divisor}) : rem_in;
        rem_d   = step ? {diff[10:0], 1'b0} : rem_q;
        q_d     = step ? {q_in[10:0], ge} : q_q;
        mb_d    = divisor;
        if (start) begin
            count_d = 4'd1;
        end else if (step) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Step counter; parks at 12 when idle so done stays high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= N_STEPS;
        end else begin
            count_q <= count_d;
        end
    end

    // Datapath registers carry no reset
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        q_q   <= q_d;
        mb_q  <= mb_d;
    end

    assign done   = (count_q == N_STEPS);
    assign q      = q_q;
    assign sticky = |rem_q;

endmodule

// File: rtl/fp16_divider.sv
// Iterative binary16 divider a / b with valid/ready on both sides.
// Special operands finish the cycle after acceptance; normal operands run
// the 12-step mantissa core, one rounding cycle, then present the result.
// Optional macro FP16_DIV_SUBNORMAL_EN: produce subnormal results instead of
// flushing underflow to zero.
module fp16_divider
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic        out_dbz
);

    div_state_e        state_q, state_d;
    logic [15:0]       out_q, out_d;
    logic              dbz_q, dbz_d;
    logic              vld_q, vld_d;
    logic              sign_q, sign_d;
    logic signed [6:0] exp_q, exp_d;

    logic              core_start, core_done, core_sticky, ma_lt_mb;
    logic [11:0]       core_q;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [10:0]       ma, mb;
    logic              s, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic              special, spec_dbz;
    logic [15:0]       spec_out;
    logic signed [6:0] exp_new;

    // Round the quotient to binary16 (RNE), handling overflow and underflow
    function automatic logic [15:0] round_result(input logic sgn, input logic signed [6:0] e,
                                                 input logic [11:0] qv, input logic stk);
        logic [11:0]       sum;
        logic signed [6:0] e_n;
        logic [15:0]       res;
`ifdef FP16_DIV_SUBNORMAL_EN
        logic [6:0]  sh7;
        logic [3:0]  shamt;
        logic [23:0] ext;
        logic [10:0] mant_s;
        logic [10:0] frac_s;
        logic        st_s;
`endif
        sum = {1'b0, qv[11:1]} + {11'd0, qv[0] & (stk | qv[1])};
        e_n = sum[11] ? (e + 7'sd1) : e;
        if (e <= 7'sd0) begin
`ifdef FP16_DIV_SUBNORMAL_EN
            sh7    = 7'd1 - e;
            shamt  = (sh7 > 7'd12) ? 4'd12 : sh7[3:0];
            ext    = {qv, 12'd0} >> shamt;
            mant_s = ext[23:13];
            st_s   = stk | (|ext[11:0]);
            frac_s = mant_s + {10'd0, ext[12] & (st_s | mant_s[0])};
            res    = {sgn, 4'd0, frac_s};
`else
            res = {sgn, 15'h0000};
`endif
        end else if (e_n >= 7'sd31) begin
            res = {sgn, FP16_INF};
        end else begin
            res = {sgn, e_n[4:0], sum[11] ? 10'd0 : sum[9:0]};
        end
        return res;
    endfunction

    fp16_mant_divider u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (core_start),
        .ma     (ma),
        .mb     (mb),
        .preset (ma_lt_mb),
        .done   (core_done),
        .q      (core_q),
        .sticky (core_sticky)
    );

    // Operand decode and special-case resolution (exp == 0 treated as zero)
    always_comb begin
        exp_a    = a[14:10];
        exp_b    = b[14:10];
        ma       = {1'b1, a[FRAC_W-1:0]};
        mb       = {1'b1, b[FRAC_W-1:0]};
        s        = a[15] ^ b[15];
        zero_a   = (exp_a == 5'd0);
        zero_b   = (exp_b == 5'd0);
        inf_a    = (exp_a == 5'h1f) && (a[9:0] == 10'd0);
        inf_b    = (exp_b == 5'h1f) && (b[9:0] == 10'd0);
        nan_a    = (exp_a == 5'h1f) && (a[9:0] != 10'd0);
        nan_b    = (exp_b == 5'h1f) && (b[9:0] != 10'd0);
        ma_lt_mb = ma < mb;
        exp_new  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 7'(FP16_BIAS)
                   - (ma_lt_mb ? 7'sd1 : 7'sd0);
        special  = 1'b1;
        spec_dbz = 1'b0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_out = FP16_QNAN;
        end else if (inf_a || zero_b) begin
            spec_out = {s, FP16_INF};
            spec_dbz = zero_b && !inf_a;
        end else if (zero_a || inf_b) begin
            spec_out = {s, 15'h0000};
        end else begin
            spec_out = 16'h0000;
            special  = 1'b0;
        end
    end

    // Control FSM next-state and result registers
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        dbz_d      = dbz_q;
        vld_d      = vld_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        core_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (special) begin
                        out_d   = spec_out;
                        dbz_d   = spec_dbz;
                        vld_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        core_start = 1'b1;
                        sign_d     = s;
                        exp_d      = exp_new;
                        state_d    = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (core_done) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                out_d   = round_result(sign_q, exp_q, core_q, core_sticky);
                dbz_d   = 1'b0;
                vld_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            out_q   <= 16'h0000;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            out_q   <= out_d;
            dbz_q   <= dbz_d;
        end
    end

    // Captured sign and exponent for the normal path
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = vld_q;
    assign out       = out_q;
    assign out_dbz   = dbz_q;

endmodule
